// File: rtl/pic_pkg.sv
// pic_pkg: types and constants shared by the 8259A PIC model blocks.
package pic_pkg;

  // Sequencer states for the 8086-mode two-pulse INTA cycle.
  typedef enum logic [2:0] {
    IDLE,
    INT_PEND,
    WAIT_PACK,
    WAIT_INTA2,
    WAIT_VACK,
    DRIVE
  } state_t;

  // IR level reported when INTA arrives with no request pending.
  localparam logic [2:0] SPURIOUS_LEVEL = 3'b111;

endpackage

// File: rtl/inta_edge_sync.sv
// inta_edge_sync: brings the asynchronous INTA_n pin into the clk domain and
// produces one-cycle fall/rise pulses from the last synchronizer stage.
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the pin through the synchronizer and keep the previous last-stage value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      prev_q <= sync_out;
    end
  end

  // Edges compare the last stage with its value one clk earlier.
  assign fall = prev_q & ~sync_out;
  assign rise = ~prev_q & sync_out;

endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: initiator side of the ISR handshake. Raises INT, follows the
// two INTA_n pulses, issues level requests to the ISR and waits for toggle acks.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intRequest,
  input  logic [2:0] highestIndex,
  input  logic       INTA_n,
  input  logic       readPriorityAck,
  input  logic       sendVectorAck,
  output logic       INT,
  output logic [2:0] toSet,
  output logic       readPriority,
  output logic       sendVector,
  output logic       secondACK,
  output logic       dataBusEnable,
  output logic       protocolError
);

  localparam int                CNT_W        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pack_prev_q, pack_prev_d;
  logic             vack_prev_q, vack_prev_d;

  logic             int_d;
  logic [2:0]       to_set_d;
  logic             read_pri_d;
  logic             send_vec_d;
  logic             second_ack_d;
  logic             dbe_d;
  logic             perr_d;
  logic             abort;

  logic             inta_fall;
  logic             inta_rise;
  logic             pack_seen;
  logic             vack_seen;
  logic             timed_out;

  inta_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .inta_n (INTA_n),
    .fall   (inta_fall),
    .rise   (inta_rise)
  );

  // A toggle ack is pending whenever the pin differs from the last consumed value.
  assign pack_seen = readPriorityAck != pack_prev_q;
  assign vack_seen = sendVectorAck != vack_prev_q;

  // The final cycle of the ack window: without an ack this edge declares a timeout.
  assign timed_out = cnt_q == TIMEOUT_LAST;

  // State, outputs, ack history and timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pack_prev_q   <= 1'b0;
      vack_prev_q   <= 1'b0;
      INT           <= 1'b0;
      toSet         <= 3'b000;
      readPriority  <= 1'b0;
      sendVector    <= 1'b0;
      secondACK     <= 1'b0;
      dataBusEnable <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pack_prev_q   <= pack_prev_d;
      vack_prev_q   <= vack_prev_d;
      INT           <= int_d;
      toSet         <= to_set_d;
      readPriority  <= read_pri_d;
      sendVector    <= send_vec_d;
      secondACK     <= second_ack_d;
      dataBusEnable <= dbe_d;
      protocolError <= perr_d;
    end
  end

  // Next-state and next-output decode for the INTA handshake.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = '0;
    pack_prev_d  = pack_prev_q;
    vack_prev_d  = vack_prev_q;
    int_d        = INT;
    to_set_d     = toSet;
    read_pri_d   = readPriority;
    send_vec_d   = sendVector;
    second_ack_d = 1'b0;
    dbe_d        = dataBusEnable;
    perr_d       = protocolError;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        int_d = 1'b0;
        if (inta_fall) begin
          // INTA with nothing pending: report the spurious level.
          to_set_d   = SPURIOUS_LEVEL;
          read_pri_d = 1'b1;
          state_d    = WAIT_PACK;
        end else if (intRequest) begin
          int_d   = 1'b1;
          state_d = INT_PEND;
        end
      end

      INT_PEND: begin
        if (inta_fall) begin
          to_set_d   = highestIndex;
          read_pri_d = 1'b1;
          state_d    = WAIT_PACK;
        end else if (!intRequest) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end
      end

      WAIT_PACK: begin
        // INTA #1 rising here is legal and deliberately not looked at.
        cnt_d = cnt_q + 1'b1;
        if (pack_seen) begin
          pack_prev_d = readPriorityAck;
          read_pri_d  = 1'b0;
          int_d       = 1'b0;
          state_d     = WAIT_INTA2;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      WAIT_INTA2: begin
        if (inta_fall) begin
          send_vec_d = 1'b1;
          state_d    = WAIT_VACK;
        end
      end

      WAIT_VACK: begin
        cnt_d = cnt_q + 1'b1;
        if (vack_seen) begin
          vack_prev_d = sendVectorAck;
          send_vec_d  = 1'b0;
          dbe_d       = 1'b1;
          state_d     = DRIVE;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      DRIVE: begin
        if (inta_rise) begin
          dbe_d        = 1'b0;
          second_ack_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        abort = 1'b1;
      end
    endcase

    // A missing ack drops every request and parks the sequencer with the error flagged.
    if (abort) begin
      perr_d     = 1'b1;
      int_d      = 1'b0;
      read_pri_d = 1'b0;
      send_vec_d = 1'b0;
      dbe_d      = 1'b0;
      state_d    = IDLE;
    end

    // Every state entry restarts the ack window.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

endmodule
